// File: rtl/vga_frame_sequencer_if.sv
// Control and status bundle for the animation frame sequencer.
// The master side, such as a button front-end or a testbench, drives sync and
// user controls. The slave side, the sequencer, returns the frame selection.
interface vga_frame_sequencer_if #(
  parameter int AW = 18
);
  logic          vs;
  logic          play_btn;
  logic          step_fwd;
  logic          step_back;
  logic          mode_pingpong;
  logic [6:0]    hold_sel;
  logic [AW-1:0] frame_base_addr;
  logic [3:0]    frame_idx;
  logic          frame_tick;
  logic          paused;

  modport master (
    output vs, play_btn, step_fwd, step_back, mode_pingpong, hold_sel,
    input  frame_base_addr, frame_idx, frame_tick, paused
  );

  modport slave (
    input  vs, play_btn, step_fwd, step_back, mode_pingpong, hold_sel,
    output frame_base_addr, frame_idx, frame_tick, paused
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// Animation playback controller. It selects which stored frame the display
// reads. Frame changes happen only on the falling edge of VS, so a frame is
// never switched mid-scan. The base address is tracked incrementally alongside
// the index, so no multiplier is needed.
module vga_frame_sequencer #(
  parameter int FRAME_COUNT = 5,
  parameter int FRAME_SIZE  = 30000,
  parameter int AW          = 18
) (
  input  logic                  pclk,
  input  logic                  rstn,
  vga_frame_sequencer_if.slave  bus
);

  localparam logic [0:0]    ST_PLAY   = 1'b0;
  localparam logic [0:0]    ST_PAUSE  = 1'b1;
  localparam logic          DIR_FWD   = 1'b0;
  localparam logic          DIR_BACK  = 1'b1;
  localparam logic [1:0]    PEND_NONE = 2'd0;
  localparam logic [1:0]    PEND_FWD  = 2'd1;
  localparam logic [1:0]    PEND_BACK = 2'd2;

  localparam logic [3:0]    LAST_IDX  = 4'(FRAME_COUNT - 1);
  localparam logic [AW-1:0] FS        = AW'(FRAME_SIZE);
  localparam logic [AW-1:0] LAST_BASE = AW'((FRAME_COUNT - 1) * FRAME_SIZE);

  logic          vs_d_q;
  logic [0:0]    state_q, state_d;
  logic          dir_q, dir_d;
  logic [6:0]    hold_cnt_q, hold_cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic [3:0]    idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic          tick_q, tick_d;

  logic          vs_fall;
  logic [6:0]    hold_last;
  logic [3:0]    idx_inc, idx_dec;
  logic [AW-1:0] base_inc, base_dec;

  assign vs_fall   = vs_d_q & ~bus.vs;
  // A hold of 0 behaves like 1, so the last hold count is clamped at 0.
  assign hold_last = (bus.hold_sel == 7'd0) ? 7'd0 : bus.hold_sel - 7'd1;

  // These are the wrapping neighbours of the current frame.
  // Loop mode, ping-pong mode and manual steps all pick from them.
  assign idx_inc  = (idx_q == LAST_IDX) ? 4'd0          : idx_q + 4'd1;
  assign base_inc = (idx_q == LAST_IDX) ? {AW{1'b0}}    : base_q + FS;
  assign idx_dec  = (idx_q == 4'd0)     ? LAST_IDX      : idx_q - 4'd1;
  assign base_dec = (idx_q == 4'd0)     ? LAST_BASE     : base_q - FS;

  // Next-state logic for playback.
  // The VS-fall action sees the state from before the toggle.
  // A play_btn then overrides any step pulse seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    hold_cnt_d = hold_cnt_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    base_d     = base_q;

    if (vs_fall) begin
      if (state_q == ST_PLAY) begin
        // Use >= so that a lowered hold_sel takes effect on the next VS.
        if (hold_cnt_q >= hold_last) begin
          hold_cnt_d = 7'd0;
          if (!bus.mode_pingpong) begin
            dir_d  = DIR_FWD;
            idx_d  = idx_inc;
            base_d = base_inc;
          end else if (FRAME_COUNT > 1) begin
            // Bounce at the endpoints so that the endpoints are not repeated.
            if (dir_q == DIR_FWD) begin
              if (idx_q == LAST_IDX) begin
                dir_d  = DIR_BACK;
                idx_d  = idx_dec;
                base_d = base_dec;
              end else begin
                idx_d  = idx_inc;
                base_d = base_inc;
              end
            end else begin
              if (idx_q == 4'd0) begin
                dir_d  = DIR_FWD;
                idx_d  = idx_inc;
                base_d = base_inc;
              end else begin
                idx_d  = idx_dec;
                base_d = base_dec;
              end
            end
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 7'd1;
        end
      end else begin
        if (pend_q == PEND_FWD) begin
          idx_d  = idx_inc;
          base_d = base_inc;
        end else if (pend_q == PEND_BACK) begin
          idx_d  = idx_dec;
          base_d = base_dec;
        end
        pend_d = PEND_NONE;
      end
    end

    if (bus.play_btn) begin
      state_d = ~state_q;
      if (state_q == ST_PAUSE) begin
        hold_cnt_d = 7'd0;
        pend_d     = PEND_NONE;
      end
    end else if ((state_q == ST_PAUSE) && (bus.step_fwd ^ bus.step_back)) begin
      pend_d = bus.step_fwd ? PEND_FWD : PEND_BACK;
    end

    tick_d = (idx_d != idx_q);
  end

  // Register the state with a synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      vs_d_q     <= 1'b0;
      state_q    <= ST_PLAY;
      dir_q      <= DIR_FWD;
      hold_cnt_q <= 7'd0;
      pend_q     <= PEND_NONE;
      idx_q      <= 4'd0;
      base_q     <= {AW{1'b0}};
      tick_q     <= 1'b0;
    end else begin
      vs_d_q     <= bus.vs;
      state_q    <= state_d;
      dir_q      <= dir_d;
      hold_cnt_q <= hold_cnt_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.frame_idx       = idx_q;
  assign bus.frame_base_addr = base_q;
  assign bus.frame_tick      = tick_q;
  assign bus.paused          = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for the frame sequencer.
// A reference model tracks frame position as a phase around the playback cycle.
// Directed scenarios run first, then a randomized mix of controls.
module tb_vga_frame_sequencer;
  localparam int FC = 5;
  localparam int FS = 30000;
  localparam int AW = 18;

  logic pclk = 1'b0;
  logic rstn = 1'b0;

  vga_frame_sequencer_if #(.AW(AW)) bus ();

  vga_frame_sequencer #(.FRAME_COUNT(FC), .FRAME_SIZE(FS), .AW(AW)) dut (
    .pclk (pclk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  int tests_run    = 0;
  int tests_failed = 0;
  int tick_cycles  = 0;

  // Count every cycle in which frame_tick is high.
  always @(negedge pclk) if (bus.frame_tick === 1'b1) tick_cycles++;

  // Reference model state.
  int m_idx;
  bit m_back;
  bit m_paused;
  int m_hold;
  int m_pend;   // 0 = none, 1 = forward, 2 = back

  function automatic void m_reset();
    m_idx = 0; m_back = 0; m_paused = 0; m_hold = 0; m_pend = 0;
  endfunction

  // Treat ping-pong as a walk around a cycle of 2*(FC-1) phases.
  function automatic void m_advance(input bit pingpong);
    int period, phase;
    if (FC == 1) return;
    if (!pingpong) begin
      m_idx  = (m_idx + 1) % FC;
      m_back = 0;
      return;
    end
    period = 2 * (FC - 1);
    if (m_idx == 0)           phase = 0;
    else if (m_idx == FC - 1) phase = FC - 1;
    else                      phase = m_back ? period - m_idx : m_idx;
    phase  = (phase + 1) % period;
    m_idx  = (phase < FC) ? phase : period - phase;
    m_back = (phase >= FC - 1);
  endfunction

  function automatic bit m_vsync(input int hold_sel, input bit pingpong);
    int h, old;
    old = m_idx;
    h   = (hold_sel == 0) ? 1 : hold_sel;
    if (!m_paused) begin
      if (m_hold >= h - 1) begin
        m_advance(pingpong);
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end else begin
      if (m_pend == 1)      m_idx = (m_idx + 1) % FC;
      else if (m_pend == 2) m_idx = (m_idx + FC - 1) % FC;
      m_pend = 0;
    end
    return (m_idx != old);
  endfunction

  // Generate one VS period.
  // Return frame_tick just after the falling-edge update and one cycle later.
  task automatic do_vsync(output logic tick_now, output logic tick_after, output bit exp_tick);
    @(negedge pclk) bus.vs = 1'b1;
    @(negedge pclk);
    @(negedge pclk) bus.vs = 1'b0;
    exp_tick = m_vsync(int'(bus.hold_sel), bus.mode_pingpong);
    @(negedge pclk) tick_now = bus.frame_tick;
    @(negedge pclk) tick_after = bus.frame_tick;
  endtask

  // Drive one-cycle control pulses and mirror them in the model.
  task automatic pulse(input bit p, input bit f, input bit b);
    @(negedge pclk);
    bus.play_btn = p; bus.step_fwd = f; bus.step_back = b;
    if (p) begin
      if (m_paused) begin m_hold = 0; m_pend = 0; end
      m_paused = !m_paused;
    end else if (m_paused && (f ^ b)) begin
      m_pend = f ? 1 : 2;
    end
    @(negedge pclk);
    bus.play_btn = 1'b0; bus.step_fwd = 1'b0; bus.step_back = 1'b0;
  endtask

  task automatic test_reset();
    bus.vs = 0; bus.play_btn = 0; bus.step_fwd = 0; bus.step_back = 0;
    bus.mode_pingpong = 0; bus.hold_sel = 7'd1;
    rstn = 1'b0;
    repeat (3) @(negedge pclk);
    rstn = 1'b1;
    m_reset();
    @(negedge pclk);
    tests_run++;
    if (bus.frame_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_idx got %0d want 0", bus.frame_idx); end
    tests_run++;
    if (bus.frame_base_addr !== 18'd0) begin tests_failed++; $display("FAIL reset_base got %0d want 0", bus.frame_base_addr); end
    tests_run++;
    if (bus.frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %b want 0", bus.frame_tick); end
    tests_run++;
    if (bus.paused !== 1'b0) begin tests_failed++; $display("FAIL reset_paused got %b want 0", bus.paused); end
  endtask

  task automatic test_loop_hold4();
    logic tn, ta; bit et; int t0;
    bus.mode_pingpong = 0; bus.hold_sel = 7'd4;
    t0 = tick_cycles;
    for (int i = 1; i <= 20; i++) begin
      do_vsync(tn, ta, et);
      tests_run++;
      if (bus.frame_idx !== 4'((i / 4) % FC)) begin tests_failed++; $display("FAIL loop_idx vs%0d got %0d want %0d", i, bus.frame_idx, (i / 4) % FC); end
      tests_run++;
      if (bus.frame_base_addr !== 18'(((i / 4) % FC) * FS)) begin tests_failed++; $display("FAIL loop_base vs%0d got %0d want %0d", i, bus.frame_base_addr, ((i / 4) % FC) * FS); end
      tests_run++;
      if (tn !== logic'(i % 4 == 0) || ta !== 1'b0) begin tests_failed++; $display("FAIL loop_tick vs%0d got %b/%b want %b/0", i, tn, ta, (i % 4 == 0)); end
    end
    tests_run++;
    if (tick_cycles - t0 != 5) begin tests_failed++; $display("FAIL loop_tick_count got %0d want 5", tick_cycles - t0); end
  endtask

  task automatic test_pingpong();
    logic tn, ta; bit et;
    int exp_pp [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    bus.mode_pingpong = 1; bus.hold_sel = 7'd1;
    for (int i = 0; i < 10; i++) begin
      do_vsync(tn, ta, et);
      tests_run++;
      if (bus.frame_idx !== 4'(exp_pp[i])) begin tests_failed++; $display("FAIL pp_idx step%0d got %0d want %0d", i, bus.frame_idx, exp_pp[i]); end
      tests_run++;
      if (bus.frame_base_addr !== 18'(exp_pp[i] * FS)) begin tests_failed++; $display("FAIL pp_base step%0d got %0d want %0d", i, bus.frame_base_addr, exp_pp[i] * FS); end
      tests_run++;
      if (tn !== 1'b1) begin tests_failed++; $display("FAIL pp_tick step%0d got %b want 1", i, tn); end
    end
  endtask

  task automatic test_pause_step_back();
    logic tn, ta; bit et; int t0;
    bus.mode_pingpong = 0; bus.hold_sel = 7'd1;
    while (m_idx != 0) do_vsync(tn, ta, et);
    pulse(1, 0, 0);
    tests_run++;
    if (bus.paused !== 1'b1) begin tests_failed++; $display("FAIL pause_flag got %b want 1", bus.paused); end
    pulse(0, 0, 1);
    repeat (3) @(negedge pclk);
    tests_run++;
    if (bus.frame_idx !== 4'd0) begin tests_failed++; $display("FAIL step_waits_vs got %0d want 0", bus.frame_idx); end
    t0 = tick_cycles;
    do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd4 || bus.frame_base_addr !== 18'd120000) begin
      tests_failed++; $display("FAIL step_back_wrap got idx %0d base %0d want 4 120000", bus.frame_idx, bus.frame_base_addr);
    end
    tests_run++;
    if (tn !== 1'b1 || tick_cycles - t0 != 1) begin tests_failed++; $display("FAIL step_back_tick got %b count %0d want 1 1", tn, tick_cycles - t0); end
  endtask

  task automatic test_step_cancel();
    logic tn, ta; bit et;
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd3) begin tests_failed++; $display("FAIL latest_step_wins got %0d want 3", bus.frame_idx); end
    pulse(0, 1, 1);
    do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd3 || tn !== 1'b0) begin tests_failed++; $display("FAIL both_steps_ignored got idx %0d tick %b want 3 0", bus.frame_idx, tn); end
  endtask

  task automatic test_hold();
    logic tn, ta; bit et;
    int exp_h0 [3] = '{4, 0, 1};
    pulse(1, 0, 0);
    tests_run++;
    if (bus.paused !== 1'b0) begin tests_failed++; $display("FAIL resume_flag got %b want 0", bus.paused); end
    bus.mode_pingpong = 0; bus.hold_sel = 7'd0;
    for (int i = 0; i < 3; i++) begin
      do_vsync(tn, ta, et);
      tests_run++;
      if (bus.frame_idx !== 4'(exp_h0[i]) || tn !== 1'b1) begin tests_failed++; $display("FAIL hold0 step%0d got idx %0d tick %b want %0d 1", i, bus.frame_idx, tn, exp_h0[i]); end
    end
    bus.hold_sel = 7'd8;
    for (int i = 0; i < 5; i++) do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd1) begin tests_failed++; $display("FAIL hold8_no_advance got %0d want 1", bus.frame_idx); end
    bus.hold_sel = 7'd2;
    do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd2 || tn !== 1'b1) begin tests_failed++; $display("FAIL hold_reduce got idx %0d tick %b want 2 1", bus.frame_idx, tn); end
  endtask

  task automatic test_reset_midway();
    logic tn, ta; bit et;
    bus.mode_pingpong = 1; bus.hold_sel = 7'd1;
    for (int i = 0; i < 3; i++) do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd3) begin tests_failed++; $display("FAIL pp_back_setup got %0d want 3", bus.frame_idx); end
    @(negedge pclk) rstn = 1'b0;
    @(negedge pclk) rstn = 1'b1;
    m_reset();
    tests_run++;
    if (bus.frame_idx !== 4'd0 || bus.frame_base_addr !== 18'd0 || bus.paused !== 1'b0) begin
      tests_failed++; $display("FAIL midreset got idx %0d base %0d paused %b want 0 0 0", bus.frame_idx, bus.frame_base_addr, bus.paused);
    end
    do_vsync(tn, ta, et);
    tests_run++;
    if (bus.frame_idx !== 4'd1 || bus.frame_base_addr !== 18'(FS)) begin
      tests_failed++; $display("FAIL midreset_next got idx %0d base %0d want 1 %0d", bus.frame_idx, bus.frame_base_addr, FS);
    end
  endtask

  task automatic test_random();
    logic tn, ta; bit et; int r;
    for (int i = 0; i < 200; i++) begin
      r  = int'($urandom_range(0, 10));
      tn = 1'b0; ta = 1'b0; et = 1'b0;
      case (r)
        0, 1, 2, 3: do_vsync(tn, ta, et);
        4: pulse(1, 0, 0);
        5: pulse(0, 1, 0);
        6: pulse(0, 0, 1);
        7: pulse(0, 1, 1);
        8: bus.hold_sel = 7'($urandom_range(0, 4));
        9: bus.mode_pingpong = ~bus.mode_pingpong;
        default: begin
          @(negedge pclk) rstn = 1'b0;
          @(negedge pclk) rstn = 1'b1;
          m_reset();
        end
      endcase
      @(negedge pclk);
      tests_run++;
      if (bus.frame_idx !== 4'(m_idx) || bus.frame_base_addr !== 18'(m_idx * FS) || bus.paused !== logic'(m_paused)) begin
        tests_failed++;
        $display("FAIL rand_state it%0d op%0d got idx %0d base %0d paused %b want %0d %0d %b",
                 i, r, bus.frame_idx, bus.frame_base_addr, bus.paused, m_idx, m_idx * FS, m_paused);
      end
      if (r <= 3) begin
        tests_run++;
        if (tn !== logic'(et) || ta !== 1'b0) begin tests_failed++; $display("FAIL rand_tick it%0d got %b/%b want %b/0", i, tn, ta, et); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop_hold4();
    test_pingpong();
    test_pause_step_back();
    test_step_cancel();
    test_hold();
    test_reset_midway();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Stop the run if the sequence above never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_frame_sequencer.md
Name: vga_frame_sequencer

Overview:
Playback controller that produces the frame base address added to the DDP read address (0..FRAME_SIZE-1) to form the VRAM address of a multi-frame animation. It replaces a fixed free-running frame counter with play/pause, single-step forward/back, programmable hold time, and loop or ping-pong ordering. Frame changes occur only on the VS falling edge, so a displayed frame never tears.

Parameters:
FRAME_COUNT  5  number of stored frames; legal range 1..16.
FRAME_SIZE  30000  words per frame (200x150).
AW  18  VRAM address width; FRAME_COUNT*FRAME_SIZE must not exceed 2^AW.

Ports:
pclk  in  1  pixel clock.
rstn  in  1  synchronous, active-low reset.
vs  in  1  vertical sync from DST.
play_btn  in  1  one-cycle pulse (pre-debounced); toggles PLAY/PAUSE.
step_fwd  in  1  one-cycle pulse; request +1 frame while paused.
step_back  in  1  one-cycle pulse; request -1 frame while paused.
mode_pingpong  in  1  0 = loop ordering, 1 = ping-pong ordering.
hold_sel  in  7  VS periods each frame is shown; 0 is treated as 1.
frame_base_addr  out  AW  frame_idx*FRAME_SIZE, registered.
frame_idx  out  4  current frame index, registered.
frame_tick  out  1  one-cycle pulse when frame_idx changes.
paused  out  1  1 in PAUSE state.

Behaviour:
- Reset (rstn=0 at a pclk edge): frame_idx=0, frame_base_addr=0, frame_tick=0, paused=0, state=PLAY, dir=forward, hold_cnt=0, pending step=none, vs_d=0.
- Edge detect: vs_d registers vs; vs_fall = vs_d & ~vs (combinational). All frame updates occur on the pclk edge where vs_fall=1; new frame_idx/frame_base_addr are visible the next cycle, with frame_tick=1 in that same cycle only.
- Effective hold: H = (hold_sel==0) ? 1 : hold_sel.
- PLAY state: on each vs_fall, if hold_cnt >= H-1, advance one frame and clear hold_cnt; otherwise hold_cnt+1. Use >= so that reducing hold_sel mid-count advances on the next vs_fall.
- PAUSE state: hold_cnt frozen. A step pulse sets pending = fwd or back; the latest pulse wins. The pending step is applied at the next vs_fall, then cleared. Step pulses in PLAY are ignored.
- play_btn: toggles state on the cycle it is seen; paused updates the next cycle. Entering PLAY clears hold_cnt and pending.
- Simultaneous inputs in one cycle:
  - play_btn with any step: play_btn wins, the step is dropped.
  - step_fwd with step_back: both ignored.
  - play_btn with vs_fall: the vs_fall action uses the pre-toggle state.
- Loop advance:
  - Forward: idx FRAME_COUNT-1 -> 0, base -> 0; otherwise idx+1, base+FRAME_SIZE.
  - dir is forced to forward on any advance made while mode_pingpong=0.
- Ping-pong advance:
  - Move in dir. At idx FRAME_COUNT-1 while forward: set dir=back, go to FRAME_COUNT-2.
  - At idx 0 while back: set dir=fwd, go to 1.
  - The endpoints are not repeated.
- Manual steps ignore dir and mode. Forward step from the last frame wraps to 0. Back step from 0 wraps to FRAME_COUNT-1, with base = (FRAME_COUNT-1)*FRAME_SIZE as an elaborated constant.
- FRAME_COUNT==1: idx and base stay 0 and frame_tick never asserts; hold_cnt still counts.
- Arithmetic: base is kept incrementally (+/-FRAME_SIZE at AW bits), with no multiplier; it must always equal idx*FRAME_SIZE.
- frame_tick asserts only if idx actually changed.
- Reset mid-operation: all state returns to reset values at the next edge; no pending step survives.

Test Plan:
- Reset, PLAY, hold_sel=4, 20 VS periods -> idx steps 0,1,2,3,4,0 every 4 vs_fall; base 0,30000,60000,90000,120000,0; frame_tick pulses exactly 5 times, each 1 cycle after vs_fall.
- mode_pingpong=1, hold_sel=1, 10 vs_fall -> idx sequence 1,2,3,4,3,2,1,0,1,2; base matches idx*30000.
- At idx 0, play_btn -> paused=1. step_back with no vs_fall -> idx stays 0. At next vs_fall -> idx 4, base 120000, one frame_tick.
- Paused: step_fwd then step_back before vs_fall -> idx decrements by one only. step_fwd and step_back in the same cycle -> no change.
- hold_sel=0 -> advance on every vs_fall. hold_sel changed from 8 to 2 when hold_cnt=5 -> advance at the next vs_fall.
- Assert rstn=0 for one cycle at idx 3 in ping-pong back direction -> idx 0, base 0, paused 0, dir forward. The next advance goes to idx 1.
